// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS main control: state codes, opcodes,
// datapath mux selects and the control word produced by the output decoder.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_BRANCHNE = 4'd13,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Pure state -> control word decoder. FETCH write enables and MEMWR retire are
// raw here; the top qualifies them with MemReady.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MEMTOREG_MDR;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_RD;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH, S_BRANCHNE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = (state == S_BRANCH);
        ctrl.branch_ne = (state == S_BRANCHNE);
        ctrl.retire    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.retire   = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = MEMTOREG_PC;
        ctrl.retire     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM: state register, dispatch, sticky Illegal flag
// and MemReady/Reset gating. Define MIPS_MC_BNE_EN to add bne via BRANCHNE.
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       Retire,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  cw;
  logic   run;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = S_BRANCHNE;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ALUWB, S_ADDIWB, S_MEMWB, S_BRANCH, S_BRANCHNE, S_JUMP, S_JAL:
        state_d = S_FETCH;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  mips_mc_outdec u_outdec (
    .state (state_q),
    .ctrl  (cw)
  );

  // Reset is an asynchronous abort: every strobe is masked in the reset cycle itself.
  assign run      = ~Reset;
  assign PCWrite  = run & cw.pc_write & ((state_q != S_FETCH) | MemReady);
  assign IRWrite  = run & cw.ir_write & MemReady;
  assign Retire   = run & cw.retire & ((state_q != S_MEMWR) | MemReady);
  assign Branch   = run & cw.branch;
  assign MemRead  = run & cw.mem_read;
  assign MemWrite = run & cw.mem_write;
  assign RegWrite = run & cw.reg_write;

`ifdef MIPS_MC_BNE_EN
  assign BranchNe = run & cw.branch_ne;
`else
  logic bne_unused;
  assign bne_unused = cw.branch_ne;
  assign BranchNe   = 1'b0;
`endif

  assign IorD     = cw.iord;
  assign RegDst   = cw.reg_dst;
  assign MemtoReg = cw.mem_to_reg;
  assign ALUSrcA  = cw.alu_src_a;
  assign ALUSrcB  = cw.alu_src_b;
  assign ALUOp    = cw.alu_op;
  assign PCSrc    = cw.pc_src;
  assign Illegal  = illegal_q;
  assign State    = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class cycle by cycle
// against hand-written state sequences and control values.
module tb_mips_mc_ctrl;

  logic       Clk;
  logic       Reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSrc;
  logic       RegWrite, ALUSrcA, Retire, Illegal;
  logic [3:0] State;

  int n_checks = 0;
  int n_errs   = 0;
  int retire_cnt;

  mips_mc_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Opcode   (Opcode),
    .MemReady (MemReady),
    .PCWrite  (PCWrite),
    .Branch   (Branch),
    .BranchNe (BranchNe),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSrc    (PCSrc),
    .Retire   (Retire),
    .Illegal  (Illegal),
    .State    (State)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic cyc(input string tag, input logic rdy, input logic [3:0] exp_st);
    MemReady = rdy;
    #1;
    check({tag, "_state"}, {28'd0, State}, {28'd0, exp_st});
    retire_cnt += int'(Retire);
  endtask

  task automatic adv();
    @(negedge Clk);
  endtask

  initial begin
    Reset    = 1'b1;
    MemReady = 1'b1;
    Opcode   = 6'b000000;
    repeat (3) @(negedge Clk);
    #1;
    check("rst_state",   {28'd0, State}, 32'd0);
    check("rst_illegal", {31'd0, Illegal}, 32'd0);
    check("rst_memread", {31'd0, MemRead}, 32'd0);
    check("rst_irwrite", {31'd0, IRWrite}, 32'd0);
    check("rst_pcwrite", {31'd0, PCWrite}, 32'd0);

    // R-type: 0,1,6,7,0
    Reset = 1'b0;
    retire_cnt = 0;
    cyc("r0", 1'b1, 4'd0);
    check("r0_memread", {31'd0, MemRead}, 32'd1);
    check("r0_irwrite", {31'd0, IRWrite}, 32'd1);
    check("r0_pcwrite", {31'd0, PCWrite}, 32'd1);
    check("r0_srcb",    {30'd0, ALUSrcB}, 32'd1);
    adv(); cyc("r1", 1'b1, 4'd1);
    check("r1_regwrite", {31'd0, RegWrite}, 32'd0);
    check("r1_srcb",     {30'd0, ALUSrcB}, 32'd3);
    adv(); cyc("r2", 1'b1, 4'd6);
    check("r2_regwrite", {31'd0, RegWrite}, 32'd0);
    check("r2_aluop",    {30'd0, ALUOp}, 32'd2);
    adv(); cyc("r3", 1'b1, 4'd7);
    check("r3_regwrite", {31'd0, RegWrite}, 32'd1);
    check("r3_regdst",   {30'd0, RegDst}, 32'd1);
    adv(); cyc("r4", 1'b1, 4'd0);
    check("r4_regwrite", {31'd0, RegWrite}, 32'd0);
    check("r_retires",   retire_cnt, 32'd1);

    // lw with two MemReady=0 cycles in MEMRD: 0,1,2,3,3,3,4,0
    Opcode = 6'b100011;
    retire_cnt = 0;
    cyc("lw0", 1'b1, 4'd0);
    adv(); cyc("lw1", 1'b1, 4'd1);
    adv(); cyc("lw2", 1'b1, 4'd2);
    check("lw2_srcb", {30'd0, ALUSrcB}, 32'd2);
    adv(); cyc("lw3", 1'b0, 4'd3);
    check("lw3_iord", {31'd0, IorD}, 32'd1);
    check("lw3_memread", {31'd0, MemRead}, 32'd1);
    adv(); cyc("lw4", 1'b0, 4'd3);
    check("lw4_iord", {31'd0, IorD}, 32'd1);
    adv(); cyc("lw5", 1'b1, 4'd3);
    check("lw5_iord", {31'd0, IorD}, 32'd1);
    adv(); cyc("lw6", 1'b1, 4'd4);
    check("lw6_memtoreg", {30'd0, MemtoReg}, 32'd1);
    check("lw6_regwrite", {31'd0, RegWrite}, 32'd1);
    check("lw6_regdst",   {30'd0, RegDst}, 32'd0);
    adv(); cyc("lw7", 1'b1, 4'd0);
    check("lw_retires", retire_cnt, 32'd1);

    // sw with one stalled FETCH cycle: 0,0,1,2,5,0
    Opcode = 6'b101011;
    retire_cnt = 0;
    cyc("sw0", 1'b0, 4'd0);
    check("sw0_irwrite", {31'd0, IRWrite}, 32'd0);
    check("sw0_pcwrite", {31'd0, PCWrite}, 32'd0);
    check("sw0_memread", {31'd0, MemRead}, 32'd1);
    adv(); cyc("sw1", 1'b1, 4'd0);
    check("sw1_irwrite", {31'd0, IRWrite}, 32'd1);
    adv(); cyc("sw2", 1'b1, 4'd1);
    check("sw2_irwrite", {31'd0, IRWrite}, 32'd0);
    adv(); cyc("sw3", 1'b1, 4'd2);
    adv(); cyc("sw4", 1'b1, 4'd5);
    check("sw4_memwrite", {31'd0, MemWrite}, 32'd1);
    check("sw4_retire",   {31'd0, Retire}, 32'd1);
    adv(); cyc("sw5", 1'b1, 4'd0);
    check("sw_retires", retire_cnt, 32'd1);

    // jal: 0,1,12,0
    Opcode = 6'b000011;
    cyc("jal0", 1'b1, 4'd0);
    adv(); cyc("jal1", 1'b1, 4'd1);
    adv(); cyc("jal2", 1'b1, 4'd12);
    check("jal_pcwrite",  {31'd0, PCWrite}, 32'd1);
    check("jal_pcsrc",    {30'd0, PCSrc}, 32'd2);
    check("jal_regdst",   {30'd0, RegDst}, 32'd2);
    check("jal_memtoreg", {30'd0, MemtoReg}, 32'd2);
    check("jal_regwrite", {31'd0, RegWrite}, 32'd1);
    check("jal_retire",   {31'd0, Retire}, 32'd1);
    adv(); cyc("jal3", 1'b1, 4'd0);

    // beq: 0,1,8,0
    Opcode = 6'b000100;
    cyc("beq0", 1'b1, 4'd0);
    adv(); cyc("beq1", 1'b1, 4'd1);
    adv(); cyc("beq2", 1'b1, 4'd8);
    check("beq_branch",   {31'd0, Branch}, 32'd1);
    check("beq_branchne", {31'd0, BranchNe}, 32'd0);
    check("beq_aluop",    {30'd0, ALUOp}, 32'd1);
    check("beq_pcsrc",    {30'd0, PCSrc}, 32'd1);
    check("beq_pcwrite",  {31'd0, PCWrite}, 32'd0);
    adv(); cyc("beq3", 1'b1, 4'd0);

    // addi with MemReady low in non-memory states (ignored): 0,1,9,10,0
    Opcode = 6'b001000;
    cyc("addi0", 1'b1, 4'd0);
    adv(); cyc("addi1", 1'b0, 4'd1);
    adv(); cyc("addi2", 1'b0, 4'd9);
    check("addi_srcb", {30'd0, ALUSrcB}, 32'd2);
    adv(); cyc("addi3", 1'b0, 4'd10);
    check("addi_regwrite", {31'd0, RegWrite}, 32'd1);
    check("addi_regdst",   {30'd0, RegDst}, 32'd0);
    adv(); cyc("addi4", 1'b1, 4'd0);

    // Opcode 000101
    Opcode = 6'b000101;
`ifdef MIPS_MC_BNE_EN
    cyc("bne0", 1'b1, 4'd0);
    adv(); cyc("bne1", 1'b1, 4'd1);
    adv(); cyc("bne2", 1'b1, 4'd13);
    check("bne_branchne", {31'd0, BranchNe}, 32'd1);
    check("bne_branch",   {31'd0, Branch}, 32'd0);
    check("bne_retire",   {31'd0, Retire}, 32'd1);
    adv(); cyc("bne3", 1'b1, 4'd0);
    check("bne_illegal",  {31'd0, Illegal}, 32'd0);
`else
    cyc("ill0", 1'b1, 4'd0);
    adv(); cyc("ill1", 1'b1, 4'd1);
    check("ill1_illegal", {31'd0, Illegal}, 32'd0);
    adv(); cyc("ill2", 1'b1, 4'd15);
    check("ill2_illegal",  {31'd0, Illegal}, 32'd1);
    check("ill2_branchne", {31'd0, BranchNe}, 32'd0);
    check("ill2_memread",  {31'd0, MemRead}, 32'd0);
    check("ill2_pcwrite",  {31'd0, PCWrite}, 32'd0);
    check("ill2_irwrite",  {31'd0, IRWrite}, 32'd0);
    check("ill2_retire",   {31'd0, Retire}, 32'd0);
    Opcode = 6'b000000;
    adv(); cyc("ill3", 1'b0, 4'd15);
    check("ill3_illegal", {31'd0, Illegal}, 32'd1);
    adv(); cyc("ill4", 1'b1, 4'd15);
    check("ill4_illegal",  {31'd0, Illegal}, 32'd1);
    check("ill4_regwrite", {31'd0, RegWrite}, 32'd0);
    Reset = 1'b1;
    #1;
    check("ill_rst_state",   {28'd0, State}, 32'd0);
    check("ill_rst_illegal", {31'd0, Illegal}, 32'd0);
    adv();
    Reset = 1'b0;
    cyc("ill5", 1'b1, 4'd0);
    check("ill5_memread", {31'd0, MemRead}, 32'd1);
`endif

    // Reset while stalled in MEMWR
    Opcode = 6'b101011;
    cyc("rw0", 1'b1, 4'd0);
    adv(); cyc("rw1", 1'b1, 4'd1);
    adv(); cyc("rw2", 1'b1, 4'd2);
    adv(); cyc("rw3", 1'b0, 4'd5);
    check("rw3_memwrite", {31'd0, MemWrite}, 32'd1);
    check("rw3_retire",   {31'd0, Retire}, 32'd0);
    Reset = 1'b1;
    #1;
    check("rw_rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rw_rst_state",    {28'd0, State}, 32'd0);
    check("rw_rst_retire",   {31'd0, Retire}, 32'd0);
    adv(); adv();
    Reset = 1'b0;
    cyc("rw4", 1'b1, 4'd0);
    check("rw4_illegal", {31'd0, Illegal}, 32'd0);
    check("rw4_memread", {31'd0, MemRead}, 32'd1);
    check("rw4_iord",    {31'd0, IorD}, 32'd0);
    adv(); cyc("rw5", 1'b1, 4'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle main control FSM for the MIPS core: it sequences one shared ALU and one unified memory across several cycles per instruction, replacing the single-cycle opcode decoder. It sits between the instruction register's opcode field and the datapath enables (PC, IR, register file, memory, ALU mux selects). It stretches memory states on a ready handshake and flags unsupported opcodes.

## Interface
- no parameters; all encodings are fixed constants in the package
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high
- Opcode  in  6  IR[31:26]
- MemReady  in  1  unified memory completed the current access this cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load if ALU Zero=1
- BranchNe  out  1  PC load if ALU Zero=0
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead / MemWrite  out  1 / 1  memory strobes
- IRWrite  out  1  instruction register load
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31
- MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- Retire  out  1  one-cycle pulse in the final cycle of each instruction
- Illegal  out  1  sticky unsupported-opcode flag
- State  out  4  current state, for debug

## Operation
- States and codes:
  - FETCH=0: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite are asserted only when MemReady=1.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD=3: MemRead, IorD=1.
  - MEMWB=4: RegWrite, RegDst=00, MemtoReg=01.
  - MEMWR=5: MemWrite, IorD=1.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB=7: RegWrite, RegDst=01, MemtoReg=00.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch, PCSrc=01.
  - ADDIEX=9: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB=10: RegWrite, RegDst=00, MemtoReg=00.
  - JUMP=11: PCWrite, PCSrc=10.
  - JAL=12: PCWrite, PCSrc=10, RegWrite, RegDst=10, MemtoReg=10.
  - BRANCHNE=13: same as BRANCH, but drives BranchNe instead of Branch.
  - ILLEGAL=15: all strobes 0.
- Outputs not listed for a state are 0.
- Transitions:
  - FETCH→DECODE on MemReady=1; otherwise stay in FETCH.
  - DECODE dispatches on Opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - 000011 → JAL
    - any other opcode → ILLEGAL
  - MEMADR → MEMRD for 100011, MEMWR for 101011.
  - MEMRD → MEMWB on MemReady=1; otherwise stay.
  - MEMWR → FETCH on MemReady=1; otherwise stay.
  - EXEC→ALUWB, ADDIEX→ADDIWB.
  - ALUWB, ADDIWB, MEMWB, BRANCH, BRANCHNE, JUMP, JAL → FETCH.
- ILLEGAL is terminal until Reset. Illegal=1 from the cycle after DECODE onward.
- Retire=1 in the following cycles:
  - ALUWB, ADDIWB, MEMWB, BRANCH, BRANCHNE, JUMP, JAL;
  - MEMWR when MemReady=1.
- Opcode is sampled only in DECODE and MEMADR; it is don't-care elsewhere.

## Timing
- Reset asserted: State=FETCH and Illegal=0 asynchronously. All strobes (PCWrite, Branch, BranchNe, MemRead, MemWrite, IRWrite, RegWrite, Retire) are forced 0 while Reset=1.
- First FETCH memory read begins in the first cycle after Reset deasserts.
- Reset mid-instruction aborts it; no write strobe is asserted in the reset cycle.
- Outputs are Moore, decoded combinationally from state. The exceptions are IRWrite, PCWrite, Retire and Illegal gating described above.
- Cycles with MemReady always 1:
  - beq, bne, j, jal: 3
  - R-type, addi, sw: 4
  - lw: 5
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemReady is ignored in all other states.

## Configuration
- MIPS_MC_BNE_EN defined: opcode 000101 dispatches to BRANCHNE.
- Undefined: BRANCHNE is unreachable, 000101 goes to ILLEGAL, and BranchNe is tied 0.

## Structure
- Package mips_mc_pkg holds:
  - the state enum with the codes above;
  - opcode constants;
  - RegDst, MemtoReg, ALUSrcB, ALUOp and PCSrc encodings.
- One sub-module, mips_mc_outdec: a pure state→control-word decoder.
- The top level holds the state register, next-state logic, the Illegal flop and the MemReady/Reset gating.

## Test plan
- Reset held 3 cycles, then released with MemReady=1 and Opcode=000000:
  - State sequence 0,1,6,7,0.
  - RegWrite=1 with RegDst=01 in state 7 only; Retire pulses once.
- lw (100011) with MemReady=0 for 2 cycles in MEMRD:
  - Sequence 0,1,2,3,3,3,4,0 (8 cycles).
  - IorD=1 throughout MEMRD; MemtoReg=01 in MEMWB.
- sw (101011) with MemReady=0 once in FETCH:
  - Sequence 0,0,1,2,5,0.
  - IRWrite=1 only in the second FETCH cycle; MemWrite=1 in state 5; Retire=1 there.
- jal (000011):
  - Sequence 0,1,12,0.
  - In state 12: PCWrite=1, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1.
- Opcode 000101:
  - With the macro: sequence 0,1,13,0; BranchNe=1 and Branch=0 in state 13.
  - Without it: State=15, Illegal=1 held until Reset, all strobes 0.
- Reset asserted while in MEMWR with MemReady=0:
  - MemWrite drops to 0 in the same cycle; State=0.
  - After release, Illegal=0 and the FETCH read restarts.
